// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, widths and FSM states for the digit-serial ALU
package alu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_ADC = 3'b101;

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic is_arith(input logic [OP_W-1:0] o);
    return (o == OP_ADD) || (o == OP_SUB) || (o == OP_ADC);
  endfunction

endpackage

// File: rtl/alu_digit.sv
// rtl/alu_digit.sv - combinational DIGIT-bit ALU slice with carry chain
module alu_digit
  import alu_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  input  logic [OP_W-1:0]  op,
  output logic [DIGIT-1:0] res,
  output logic             cout,
  output logic             msb_cin
);

  logic [DIGIT-1:0] bb;
  logic [DIGIT-1:0] sum;
  logic             c;

  always_comb begin
    res     = '0;
    cout    = 1'b0;
    msb_cin = 1'b0;
    sum     = '0;
    bb      = (op == OP_SUB) ? ~b : b;
    c       = cin;
    // msb_cin is the carry entering the top bit; XOR with cout gives signed overflow
    for (int i = 0; i < DIGIT; i++) begin
      sum[i] = a[i] ^ bb[i] ^ c;
      if (i == DIGIT - 1) msb_cin = c;
      c = (a[i] & bb[i]) | (c & (a[i] ^ bb[i]));
    end
    case (op)
      OP_ADD, OP_SUB, OP_ADC: begin
        res  = sum;
        cout = c;
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      default: begin
        res     = '0;
        msb_cin = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// rtl/alu_serial.sv - digit-serial ALU with start/busy/done handshake and registered flags
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Z,
  output logic             carry,
  output logic             sign,
  output logic             zero,
  output logic             parity,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N + 1 > 1) ? $clog2(N + 1) : 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr, r_nxt;
  logic [OP_W-1:0]  op_r;
  logic             cin_r;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [DIGIT-1:0] d_res;
  logic             d_cout, d_msb_cin;

  alu_digit #(.DIGIT(DIGIT)) u_digit (
    .a       (a_sr[DIGIT-1:0]),
    .b       (b_sr[DIGIT-1:0]),
    .cin     (cin_r),
    .op      (op_r),
    .res     (d_res),
    .cout    (d_cout),
    .msb_cin (d_msb_cin)
  );

  assign last  = (cnt == CW'(N - 1));
  assign busy  = (state == RUN);
  // new digit enters at the top so the LSB digit ends up at bit 0 after N shifts
  assign r_nxt = (r_sr >> DIGIT) | (WIDTH'(d_res) << (WIDTH - DIGIT));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      r_sr     <= '0;
      op_r     <= '0;
      cin_r    <= 1'b0;
      cnt      <= '0;
      Z        <= '0;
      carry    <= 1'b0;
      sign     <= 1'b0;
      zero     <= 1'b0;
      parity   <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (state == IDLE && start) begin
        a_sr  <= X;
        b_sr  <= Y;
        op_r  <= op;
        cin_r <= (op == OP_SUB) ? 1'b1 : ((op == OP_ADC) ? carry : 1'b0);
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sr  <= a_sr >> DIGIT;
        b_sr  <= b_sr >> DIGIT;
        r_sr  <= r_nxt;
        cin_r <= d_cout;
        cnt   <= cnt + CW'(1);
        if (last) begin
          Z        <= r_nxt;
          carry    <= is_arith(op_r) & d_cout;
          overflow <= is_arith(op_r) & (d_msb_cin ^ d_cout);
          sign     <= r_nxt[WIDTH-1];
          zero     <= (r_nxt == '0);
          parity   <= ~^r_nxt;
          done     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_serial.sv
// tb/tb_alu_serial.sv - randomized self-checking bench for alu_serial against an arithmetic model
module tb_alu_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start1, start16;
  logic [2:0]  op;
  logic [15:0] X, Y;

  logic [15:0] Z, Z1, Z16;
  logic        carry, sign, zero, parity, overflow, busy, done;
  logic        carry1, sign1, zero1, parity1, overflow1, busy1, done1;
  logic        carry16, sign16, zero16, parity16, overflow16, busy16, done16;

  int total = 0;
  int bad   = 0;
  logic m_carry = 1'b0;

  always #5 clk = ~clk;

  alu_serial #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .X(X), .Y(Y), .Z(Z),
    .carry(carry), .sign(sign), .zero(zero), .parity(parity), .overflow(overflow),
    .busy(busy), .done(done)
  );

  alu_serial #(.WIDTH(16), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op(op), .X(X), .Y(Y), .Z(Z1),
    .carry(carry1), .sign(sign1), .zero(zero1), .parity(parity1), .overflow(overflow1),
    .busy(busy1), .done(done1)
  );

  alu_serial #(.WIDTH(16), .DIGIT(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op), .X(X), .Y(Y), .Z(Z16),
    .carry(carry16), .sign(sign16), .zero(zero16), .parity(parity16), .overflow(overflow16),
    .busy(busy16), .done(done16)
  );

  // {Z, carry, sign, zero, parity, overflow}
  function automatic logic [20:0] model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                                        input logic ci);
    logic [16:0] s;
    logic [15:0] z;
    logic        c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (o)
      3'd0: s = {1'b0, x} + {1'b0, y};
      3'd1: s = {1'b0, x} + {1'b0, ~y} + 17'd1;
      3'd5: s = {1'b0, x} + {1'b0, y} + {16'd0, ci};
      default: s = '0;
    endcase
    case (o)
      3'd0, 3'd1, 3'd5: begin z = s[15:0]; c = s[16]; end
      3'd2: z = x & y;
      3'd3: z = x | y;
      3'd4: z = x ^ y;
      default: z = 16'd0;
    endcase
    if (o == 3'd0 || o == 3'd5) v = (x[15] == y[15]) && (z[15] != x[15]);
    if (o == 3'd1) v = (x[15] != y[15]) && (z[15] != x[15]);
    return {z, c, z[15], z == 16'd0, ($countones(z) % 2) == 0, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y, output int lat);
    op = o; X = x; Y = y; start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    total++;
    if ({Z, carry, sign, zero, parity, overflow, busy, done} !== 23'd0) begin
      bad++;
      $display("FAIL reset_dut4 got=%h want=0", {Z, carry, sign, zero, parity, overflow, busy, done});
    end
    total++;
    if ({Z1, carry1, sign1, zero1, parity1, overflow1, busy1, done1,
         Z16, carry16, sign16, zero16, parity16, overflow16, busy16, done16} !== 46'd0) begin
      bad++;
      $display("FAIL reset_degenerate got1=%h got16=%h want=0", Z1, Z16);
    end
    m_carry = 1'b0;
  endtask

  task automatic test_vectors();
    logic [2:0]  ops [5] = '{3'd0, 3'd0, 3'd5, 3'd4, 3'd1};
    logic [15:0] xs  [5] = '{16'h8fff, 16'hfffe, 16'h0001, 16'haaaa, 16'h0005};
    logic [15:0] ys  [5] = '{16'h8000, 16'h0002, 16'h0001, 16'h5555, 16'h0007};
    logic [20:0] exp [5] = '{{16'h0fff, 5'b10011}, {16'h0000, 5'b10110}, {16'h0003, 5'b00010},
                             {16'hffff, 5'b01010}, {16'hfffe, 5'b01000}};
    int lat;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], xs[i], ys[i], lat);
      total++;
      if (lat !== 4) begin
        bad++;
        $display("FAIL vec%0d_latency got=%0d want=4", i, lat);
      end
      total++;
      if ({Z, carry, sign, zero, parity, overflow} !== exp[i]) begin
        bad++;
        $display("FAIL vec%0d_result got=%h want=%h", i, {Z, carry, sign, zero, parity, overflow}, exp[i]);
      end
      m_carry = exp[i][4];
      tick();
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("FAIL vec%0d_done_width got=%b want=0", i, done);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [20:0] exp1, exp2;
    logic [15:0] z_prev;
    int n, held_bad;
    exp1 = model(3'd0, 16'h1234, 16'h1111, m_carry);
    z_prev = Z;
    held_bad = 0;
    op = 3'd0; X = 16'h1234; Y = 16'h1111; start = 1'b1;
    tick();
    X = 16'hffff; Y = 16'hffff; op = 3'd3;
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (n == 2) start = 1'b0;
      if (done) break;
      if (Z !== z_prev) held_bad++;
    end
    total++;
    if (n !== 4) begin bad++; $display("FAIL busy_ignore_latency got=%0d want=4", n); end
    total++;
    if ({Z, carry, sign, zero, parity, overflow} !== exp1) begin
      bad++;
      $display("FAIL busy_ignore_result got=%h want=%h", {Z, carry, sign, zero, parity, overflow}, exp1);
    end
    total++;
    if (held_bad !== 0) begin bad++; $display("FAIL z_hold_during_busy got=%0d changes want=0", held_bad); end
    m_carry = exp1[4];
    exp2 = model(3'd1, 16'h4000, 16'hc000, m_carry);
    op = 3'd1; X = 16'h4000; Y = 16'hc000; start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL done_cycle_accept busy got=%b want=1", busy); end
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin n = k; break; end
    end
    total++;
    if (n !== 4) begin bad++; $display("FAIL back_to_back_latency got=%0d want=4", n); end
    total++;
    if ({Z, carry, sign, zero, parity, overflow} !== exp2) begin
      bad++;
      $display("FAIL back_to_back_result got=%h want=%h", {Z, carry, sign, zero, parity, overflow}, exp2);
    end
    m_carry = exp2[4];
  endtask

  task automatic test_reset_mid();
    int dones, lat;
    logic [20:0] exp;
    op = 3'd0; X = 16'h7777; Y = 16'h1111; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_carry = 1'b0;
    total++;
    if ({Z, carry, sign, zero, parity, overflow, busy, done} !== 23'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs got=%h want=0", {Z, carry, sign, zero, parity, overflow, busy, done});
    end
    dones = 0;
    repeat (6) begin
      tick();
      if (done) dones++;
    end
    total++;
    if (dones !== 0) begin bad++; $display("FAIL reset_mid_no_done got=%0d want=0", dones); end
    exp = model(3'd0, 16'h7777, 16'h1111, m_carry);
    issue(3'd0, 16'h7777, 16'h1111, lat);
    total++;
    if (lat !== 4 || {Z, carry, sign, zero, parity, overflow} !== exp) begin
      bad++;
      $display("FAIL reset_mid_recover got=%h lat=%0d want=%h lat=4", {Z, carry, sign, zero, parity, overflow},
               lat, exp);
    end
    m_carry = exp[4];
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [15:0] x, y;
    logic [20:0] exp;
    int lat;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = 16'($urandom);
      y = 16'($urandom);
      exp = model(o, x, y, m_carry);
      issue(o, x, y, lat);
      total++;
      if (lat !== 4 || {Z, carry, sign, zero, parity, overflow} !== exp) begin
        bad++;
        $display("FAIL random%0d op=%0d x=%h y=%h got=%h lat=%0d want=%h lat=4", i, o, x, y,
                 {Z, carry, sign, zero, parity, overflow}, lat, exp);
      end
      m_carry = exp[4];
    end
  endtask

  task automatic test_degenerate();
    logic [20:0] exp;
    int n1, n16;
    exp = {16'h0fff, 5'b10011};
    op = 3'd0; X = 16'h8fff; Y = 16'h8000;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n1 = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done1) begin n1 = k; break; end
    end
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    n16 = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done16) begin n16 = k; break; end
    end
    total++;
    if (n1 !== 16) begin bad++; $display("FAIL digit1_latency got=%0d want=16", n1); end
    total++;
    if (n16 !== 1) begin bad++; $display("FAIL digit16_latency got=%0d want=1", n16); end
    total++;
    if ({Z1, carry1, sign1, zero1, parity1, overflow1} !== exp) begin
      bad++;
      $display("FAIL digit1_result got=%h want=%h", {Z1, carry1, sign1, zero1, parity1, overflow1}, exp);
    end
    total++;
    if ({Z16, carry16, sign16, zero16, parity16, overflow16} !== exp) begin
      bad++;
      $display("FAIL digit16_result got=%h want=%h", {Z16, carry16, sign16, zero16, parity16, overflow16}, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start1 = 1'b0; start16 = 1'b0;
    op = 3'd0; X = 16'd0; Y = 16'd0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_degenerate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
